alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational 4-bit ALU (add/sub/and/or/xor/not/shl/shr, 3-bit op) between NUM_REQ requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block selects a winner round-robin, registers the operands, drives the ALU for one cycle, captures result and carry, and returns them to the winner.
- It sits between client FSMs (e.g. counter/control logic) and the shared ALU instance, which lives outside this block.

Parameters:
W, 4, operand/result width; must match the ALU width.
NUM_REQ, 2, number of requesters; legal range 2..8.
IDW, $clog2(NUM_REQ), width of the grant index.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
req_a  in  NUM_REQ*W  flattened operand A; slice i is bits [i*W +: W].
req_b  in  NUM_REQ*W  flattened operand B / shift amount.
req_op  in  NUM_REQ*3  flattened opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not, 6 shl, 7 shr.
rsp_valid  out  NUM_REQ  one-hot response valid to the winner.
rsp_ready  in  NUM_REQ  per-requester response accept.
rsp_result  out  W  captured ALU result; shared by all requesters.
rsp_carry  out  1  captured ALU carry; meaningful for add/sub only.
alu_a  out  W  drives ALU a.
alu_b  out  W  drives ALU b.
alu_op  out  3  drives ALU op.
alu_result  in  W  from ALU result.
alu_carry  in  1  from ALU carry.
busy  out  1  high whenever state is not IDLE.
grant_id  out  IDW  index of the current/last winner.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state to IDLE;
  - operand, op, result and carry registers to 0;
  - last-grant pointer to NUM_REQ-1, so requester 0 wins first;
  - grant_id to 0.
- Outputs during reset: req_ready=0, rsp_valid=0, rsp_result=0, rsp_carry=0, alu_a/alu_b/alu_op=0, busy=0.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Combinational round-robin grant over req_valid, searching from (last+1) mod NUM_REQ upward with wrap.
  - If any valid: req_ready[g]=1 in the same cycle. At the edge, latch a/b/op of requester g, set last=g, grant_id=g, and go to EXEC.
  - If none valid: req_ready=0 and stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_op are driven from the operand registers; they are also held from these registers in every other state.
  - At the edge, capture alu_result and alu_carry; go to RESP.
- RESP:
  - rsp_valid[grant_id]=1; rsp_result and rsp_carry are held stable.
  - On rsp_ready[grant_id]=1, go to IDLE at that edge.
  - rsp_ready of non-granted requesters is ignored.
- Latency: request handshake at edge N, rsp_valid high from N+2. Minimum throughput: one op per 3 cycles.
- A requester must hold its request stable until it sees req_ready. The arbiter never drops a valid request; round-robin guarantees service within NUM_REQ grants.
- req_valid changing while busy has no effect. A requester may re-request in the same cycle its response completes; the request is evaluated in the following IDLE cycle.
- Width/arithmetic: no transformation inside the block. Carry is passed straight through; the ALU produces 0 carry for non-add/sub ops.
- Reset mid-operation (EXEC or RESP): the transaction is discarded and no response is delivered. Requesters must re-issue.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. The last-grant pointer is not used for selection; grant_id is still updated.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package alu_arb_pkg contains:
  - typedef enum logic [1:0] arb_state_e {IDLE, EXEC, RESP};
  - typedef enum logic [2:0] alu_op_e {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR};
  - localparam OP_W = 3.
- Sub-module rr_arbiter (parameter N): inputs req[N], last[IDW], fixed_prio; outputs one-hot gnt[N], gnt_id[IDW], any. Purely combinational.
- The FSM and registers live in alu_arbiter. The bench connects the team's existing alu to the alu_* ports.

Test Plan:
- Req0 op=0 a=9 b=8 -> req_ready[0] same cycle; rsp_valid[0] 2 cycles later; rsp_result=1, rsp_carry=1.
- Req1 op=1 a=5 b=3 -> result=2, carry=1. Then op=1 a=3 b=5 -> result=14, carry=0.
- Both valid continuously, default build -> grant order 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN -> 0,0,0 and req1 starved.
- Req0 op=6 a=4'b0011 b=1 -> result=4'b0110, carry=0. Hold rsp_ready[0]=0 for 5 cycles -> rsp_valid, rsp_result and busy stay stable; req1 is not accepted until the response completes.
- Assert rst_n=0 during EXEC -> outputs 0 immediately, state IDLE. After release, a pending req1 is granted and req0 (last=NUM_REQ-1 reset) goes first if it is also valid.
- NUM_REQ=3, valid=3'b101 after a grant to 2 -> wraps to 0, then 2.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
// Shared types for the ALU arbiter slice: the arbiter FSM state encoding,
// the opcode set understood by the shared 4-bit ALU, and the opcode width.
// Imported by rr_arbiter and alu_arbiter.
// ---------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int OP_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_e;

    typedef enum logic [OP_W-1:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NOT,
        OP_SHL,
        OP_SHR
    } alu_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational grant selector used by alu_arbiter.
// Round-robin mode searches upward from (last+1) mod N with wrap-around;
// fixed-priority mode ignores 'last' and picks the lowest requesting index.
//
// Ports:
//   req        in  N     request vector
//   last       in  IDW   index of the previous winner
//   fixed_prio in  1     1 = lowest index wins, 0 = round-robin
//   gnt        out N     one-hot grant (zero when nobody requests)
//   gnt_id     out IDW   index of the granted requester
//   any        out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    input  logic           fixed_prio,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    // Walk the N candidate slots in priority order. The first requesting
    // slot wins; 'any' doubles as the "already found" flag so later slots
    // cannot override the winner.
    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            if (fixed_prio) begin
                idx = k;
            end else begin
                idx = (int'(last) + 1 + k) % N;
            end
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational 4-bit ALU between NUM_REQ requesters.
// A winner is picked in IDLE, its operands are registered, the ALU is driven
// for one EXEC cycle, the result/carry are captured and presented in RESP
// until the winner accepts them.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                          undefined -> round-robin (default)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester request handshake
//   req_a/req_b/req_op      flattened operands/opcode, slice i = [i*W +: W]
//   rsp_valid/rsp_ready     per-requester response handshake
//   rsp_result/rsp_carry    captured ALU outputs, shared by all requesters
//   alu_a/alu_b/alu_op      drive the shared ALU (always from registers)
//   alu_result/alu_carry    returned by the shared ALU
//   busy                    high whenever the FSM is not IDLE
//   grant_id                index of the current/last winner
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int W       = 4,
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*W-1:0]    req_a,
    input  logic [NUM_REQ*W-1:0]    req_b,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [W-1:0]            rsp_result,
    output logic                    rsp_carry,
    output logic [W-1:0]            alu_a,
    output logic [W-1:0]            alu_b,
    output logic [OP_W-1:0]         alu_op,
    input  logic [W-1:0]            alu_result,
    input  logic                    alu_carry,
    output logic                    busy,
    output logic [IDW-1:0]          grant_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_e           state;
    arb_state_e           state_next;
    logic [W-1:0]         a_reg;
    logic [W-1:0]         b_reg;
    logic [OP_W-1:0]      op_reg;
    logic [W-1:0]         result_reg;
    logic                 carry_reg;
    logic [IDW-1:0]       last_ptr;
    logic [IDW-1:0]       grant_reg;
    logic [NUM_REQ-1:0]   gnt;
    logic [IDW-1:0]       gnt_id;
    logic                 gnt_any;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last       (last_ptr),
        .fixed_prio (FIXED_PRIO),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .any        (gnt_any)
    );

    // FSM state register. Reset returns to IDLE, which also discards any
    // transaction that was in EXEC or RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. Operands and the winner index are latched on the
    // accepting edge in IDLE; the ALU outputs are sampled at the end of the
    // single EXEC cycle and then held untouched through RESP. The last-grant
    // pointer resets to NUM_REQ-1 so requester 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            last_ptr   <= IDW'(NUM_REQ - 1);
            grant_reg  <= '0;
        end else begin
            if (state == IDLE && gnt_any) begin
                a_reg     <= req_a[int'(gnt_id)*W +: W];
                b_reg     <= req_b[int'(gnt_id)*W +: W];
                op_reg    <= req_op[int'(gnt_id)*OP_W +: OP_W];
                last_ptr  <= gnt_id;
                grant_reg <= gnt_id;
            end
            if (state == EXEC) begin
                result_reg <= alu_result;
                carry_reg  <= alu_carry;
            end
        end
    end

    // Next-state and handshake outputs. req_ready is the arbiter grant,
    // offered only in IDLE and masked while reset is asserted so nothing is
    // accepted during reset. Only the winner's rsp_ready can end RESP.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    req_ready  = gnt & {NUM_REQ{rst_n}};
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid[grant_reg] = 1'b1;
                if (rsp_ready[grant_reg]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign alu_a      = a_reg;
    assign alu_b      = b_reg;
    assign alu_op     = op_reg;
    assign rsp_result = result_reg;
    assign rsp_carry  = carry_reg;
    assign busy       = (state != IDLE);
    assign grant_id   = grant_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Bench for alu_arbiter with NUM_REQ=2, W=4. Provides a behavioural ALU on
// the alu_* ports, a transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
// Honours ALU_ARB_FIXED_PRIO_EN for the expected arbitration policy.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N   = 2;
    localparam int W   = 4;
    localparam int IDW = 1;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_op;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_carry;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_result;
    logic           alu_carry;
    logic           busy;
    logic [IDW-1:0] grant_id;

    int checkCount = 0;
    int passCount  = 0;
    bit randomMode = 0;

    // Reference-model state: the transaction in flight, if any.
    int         curId   = -1;
    int         respAt  = 0;
    int         cyc     = 0;
    int         lastWin = N - 1;
    int         gid     = 0;
    logic [3:0] expA, expB, expRes;
    logic [2:0] expOp;
    logic       expC;

    alu_arbiter #(
        .W       (W),
        .NUM_REQ (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain-arithmetic ALU: {carry, result}. Subtract carry means "no borrow".
    function automatic logic [4:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
        int   ia, ib, r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        r  = 0;
        c  = 1'b0;
        case (op)
            3'd0: begin r = ia + ib; c = (r > 15); end
            3'd1: begin r = ia - ib; c = (ia >= ib); end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = 15 - ia;
            3'd6: r = (ib > 3) ? 0 : (ia << ib);
            default: r = ia >> ib;
        endcase
        return {c, 4'(r & 15)};
    endfunction

    // Shared ALU stand-in hooked to the alu_* ports.
    always_comb begin
        {alu_carry, alu_result} = aluRef(alu_a, alu_b, alu_op);
    end

    // Which requester should win given the valid vector and previous winner.
    function automatic int pickWinner(input logic [N-1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
`else
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Drive one requester's request fields.
    task automatic applyStimulus(input int id, input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] op, input logic v);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_op[id*3 +: 3] = op;
        req_valid[id]    = v;
    endtask

    // Every-cycle comparison against the reference model. The model only
    // knows: a transaction is accepted when idle, its response appears two
    // cycles after acceptance and persists until the winner takes it.
    initial begin : compareProc
        int w;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                checkOutput("rst_req_ready", req_ready, 0);
                checkOutput("rst_rsp_valid", rsp_valid, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_grant_id", grant_id, 0);
                checkOutput("rst_alu", {alu_a, alu_b, alu_op}, 0);
                checkOutput("rst_rsp", {rsp_result, rsp_carry}, 0);
                curId   = -1;
                lastWin = N - 1;
                gid     = 0;
            end else if (curId < 0) begin
                w = pickWinner(req_valid, lastWin);
                checkOutput("m_req_ready", req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
                checkOutput("m_busy_idle", busy, 0);
                checkOutput("m_rsp_valid_idle", rsp_valid, 0);
                checkOutput("m_grant_id", grant_id, gid);
                if (w >= 0) begin
                    curId  = w;
                    respAt = cyc + 2;
                    expA   = req_a[w*W +: W];
                    expB   = req_b[w*W +: W];
                    expOp  = req_op[w*3 +: 3];
                    {expC, expRes} = aluRef(expA, expB, expOp);
                    lastWin = w;
                    gid     = w;
                end
            end else begin
                checkOutput("m_req_ready_busy", req_ready, 0);
                checkOutput("m_busy", busy, 1);
                checkOutput("m_grant_id_busy", grant_id, gid);
                checkOutput("m_alu_ops", {alu_a, alu_b, alu_op}, {expA, expB, expOp});
                if (cyc >= respAt) begin
                    checkOutput("m_rsp_valid", rsp_valid, 32'd1 << curId);
                    checkOutput("m_rsp_result", rsp_result, expRes);
                    checkOutput("m_rsp_carry", rsp_carry, expC);
                    if (rsp_ready[curId]) curId = -1;
                end else begin
                    checkOutput("m_rsp_valid_exec", rsp_valid, 0);
                end
            end
        end
    end

    // Random requesters: keep a request until accepted, then maybe issue a
    // new one; response acceptance is randomly throttled.
    initial begin : randomDriver
        logic [N-1:0] hs;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (randomMode) begin
                for (int i = 0; i < N; i++) begin
                    if (hs[i] || !req_valid[i]) begin
                        applyStimulus(i, 4'($urandom), 4'($urandom), 3'($urandom),
                                      ($urandom_range(0, 99) < 60));
                    end
                    rsp_ready[i] = ($urandom_range(0, 99) < 70);
                end
            end
        end
    end

    // Issue one request from 'id', wait (bounded) for acceptance and for the
    // response; returns the wait counts and the presented result.
    task automatic doOp(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, output int readyWait, output int lat,
                        output logic [3:0] res, output logic c);
        @(posedge clk);
        #1;
        applyStimulus(id, a, b, op, 1'b1);
        rsp_ready[id] = 1'b0;
        readyWait = 0;
        forever begin
            @(negedge clk);
            readyWait++;
            if (req_ready[id] || readyWait > 20) break;
        end
        checkOutput("op_accepted", req_ready[id], 1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (rsp_valid[id] || lat > 20) break;
        end
        res = rsp_result;
        c   = rsp_carry;
    endtask

    // Accept the pending response of 'id' for exactly one edge.
    task automatic finishRsp(input int id);
        @(posedge clk);
        #1;
        rsp_ready[id] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[id] = 1'b0;
    endtask

    task automatic drainAll();
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = '0;
    endtask

    // Overall time bound.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin : mainSeq
        int         rw, lat, ng;
        logic [3:0] res;
        logic       c;
        int         order[4];
        int         expOrder[4];

`ifdef ALU_ARB_FIXED_PRIO_EN
        expOrder = '{0, 0, 0, 0};
`else
        expOrder = '{0, 1, 0, 1};
`endif
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Requester 0: 9 + 8 wraps to 1 with carry.
        doOp(0, 4'd9, 4'd8, 3'd0, rw, lat, res, c);
        checkOutput("add_ready_same_cycle", rw, 1);
        checkOutput("add_latency", lat, 2);
        checkOutput("add_result", res, 4'd1);
        checkOutput("add_carry", c, 1'b1);
        finishRsp(0);

        // Requester 1: subtraction with and without borrow.
        doOp(1, 4'd5, 4'd3, 3'd1, rw, lat, res, c);
        checkOutput("sub1_result", res, 4'd2);
        checkOutput("sub1_carry", c, 1'b1);
        finishRsp(1);
        doOp(1, 4'd3, 4'd5, 3'd1, rw, lat, res, c);
        checkOutput("sub2_result", res, 4'd14);
        checkOutput("sub2_carry", c, 1'b0);
        finishRsp(1);

        // Both requesting continuously: record the grant order.
        @(posedge clk);
        #1;
        applyStimulus(0, 4'd1, 4'd2, 3'd2, 1'b1);
        applyStimulus(1, 4'd7, 4'd1, 3'd3, 1'b1);
        rsp_ready = '1;
        ng = 0;
        for (int t = 0; t < 40 && ng < 4; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                order[ng] = req_ready[1] ? 1 : 0;
                ng++;
            end
        end
        checkOutput("grant_count", ng, 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("grant_order_%0d", k), order[k], expOrder[k]);
        end
        drainAll();

        // Shift-left with a stalled response; requester 1 must wait.
        doOp(0, 4'b0011, 4'd1, 3'd6, rw, lat, res, c);
        checkOutput("shl_result", res, 4'b0110);
        checkOutput("shl_carry", c, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1, 4'd2, 4'd2, 3'd4, 1'b1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_req_ready", req_ready, 0);
            checkOutput("stall_rsp_valid", rsp_valid, 2'b01);
            checkOutput("stall_rsp_result", rsp_result, 4'b0110);
            checkOutput("stall_busy", busy, 1);
        end
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        @(negedge clk);
        checkOutput("post_stall_grant", req_ready, 2'b10);
        drainAll();

        // Reset during EXEC: transaction dropped, outputs cleared at once.
        @(posedge clk);
        #1;
        applyStimulus(0, 4'd6, 4'd1, 3'd0, 1'b1);
        @(negedge clk);
        checkOutput("pre_reset_grant", req_ready, 2'b01);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(1, 4'd4, 4'd4, 3'd0, 1'b1);
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_alu_a", alu_a, 0);
        checkOutput("async_rst_ready", req_ready, 0);
        checkOutput("async_rst_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_first", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rsp_ready    = '1;
        ng = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                ng = 1;
                break;
            end
        end
        checkOutput("post_reset_req1_served", ng, 1);
        drainAll();

        // Randomized traffic checked by the reference model.
        @(posedge clk);
        #2 randomMode = 1'b1;
        repeat (1500) @(posedge clk);
        #2 randomMode = 1'b0;
        drainAll();
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
